// File: rtl/axi_seq_pkg.sv
// axi_seq_pkg: shared state, mode and response encodings for the AXI transaction sequencer
package axi_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAW, S_WB, S_RA, S_RD} state_t;
  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_WR    = 2'b01;
  localparam logic [1:0] MODE_RD    = 2'b10;
  localparam logic [1:0] MODE_WR_RD = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/axi_seq_stall_timer.sv
// axi_seq_stall_timer: counts cycles without progress and flags a stall after TIMEOUT of them
module axi_seq_stall_timer #(
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // expired fires in the cycle the count would reach TIMEOUT; the counter restarts after it
  always_comb begin
    expired = enable & ~clear & (cnt_q == LAST);
    cnt_d = (clear | expired) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  end
  // stall count register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/axi_txn_sequencer.sv
// axi_txn_sequencer: drives single-beat AXI write/read iterations and reports completions, bad responses and stalls
module axi_txn_sequencer
  import axi_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             awvalid,
  output logic             wvalid,
  output logic             bready,
  output logic             arvalid,
  output logic             rready,
  input  logic             awready,
  input  logic             wready,
  input  logic             bvalid,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  input  logic [1:0]       bresp,
  input  logic [1:0]       rresp,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             rlast_err,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] bad_resp_cnt
);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d, launch_mode;
  logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, bad_q, bad_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, rlast_err_q, rlast_err_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, bad_hit, launch, iter_end, expired, tmr_clear;

  assign aw_hs = awvalid_q & awready;
  assign w_hs = wvalid_q & wready;
  assign b_hs = bready_q & bvalid;
  assign ar_hs = arvalid_q & arready;
  assign r_hs = rready_q & rvalid;
  assign bad_hit = (b_hs & (bresp != RESP_OKAY)) | (r_hs & (rresp != RESP_OKAY));
  assign tmr_clear = aw_hs | w_hs | b_hs | ar_hs | r_hs | (state_q == S_IDLE && start);

  axi_seq_stall_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .reset(reset), .clear(tmr_clear), .enable(busy_q), .expired(expired)
  );

  // next state, channel controls and counters; a stall abort overrides everything
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    iter_d = iter_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    bad_d = bad_q;
    timeout_d = timeout_q;
    rlast_err_d = rlast_err_q;
    busy_d = busy_q;
    done_d = 1'b0;
    awvalid_d = 1'b0;
    wvalid_d = 1'b0;
    bready_d = 1'b0;
    arvalid_d = 1'b0;
    rready_d = 1'b0;
    launch = 1'b0;
    iter_end = 1'b0;
    launch_mode = mode_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d = mode;
        cnt_d = count;
        iter_d = '0;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        bad_d = '0;
        timeout_d = 1'b0;
        rlast_err_d = 1'b0;
        launch_mode = mode;
        done_d = (mode == MODE_NONE) || (count == '0);
        launch = ~done_d;
      end
      S_WAW: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WB;
          bready_d = 1'b1;
        end
      end
      S_WB: begin
        bready_d = ~b_hs;
        if (b_hs) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (mode_q == MODE_WR_RD) begin
            state_d = S_RA;
            arvalid_d = 1'b1;
          end else iter_end = 1'b1;
        end
      end
      S_RA: begin
        arvalid_d = ~ar_hs;
        if (ar_hs) begin
          state_d = S_RD;
          rready_d = 1'b1;
        end
      end
      S_RD: begin
        rready_d = ~r_hs;
        if (r_hs) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          rlast_err_d = rlast_err_q | ~rlast;
          iter_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bad_hit && !(&bad_q)) bad_d = bad_q + 1'b1;
    if (iter_end) begin
      iter_d = iter_q + 1'b1;
      if (iter_d == cnt_q) begin
        state_d = S_IDLE;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else launch = 1'b1;
    end
    if (launch) begin
      busy_d = 1'b1;
      if (launch_mode == MODE_RD) begin
        state_d = S_RA;
        arvalid_d = 1'b1;
      end else begin
        state_d = S_WAW;
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
      end
    end
    if (expired) begin
      state_d = S_IDLE;
      awvalid_d = 1'b0;
      wvalid_d = 1'b0;
      bready_d = 1'b0;
      arvalid_d = 1'b0;
      rready_d = 1'b0;
      timeout_d = 1'b1;
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  // state and registered outputs, all cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mode_q <= MODE_NONE;
      cnt_q <= '0;
      iter_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      bad_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      rlast_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      iter_q <= iter_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      bad_q <= bad_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      rlast_err_q <= rlast_err_d;
    end

  assign awvalid = awvalid_q;
  assign wvalid = wvalid_q;
  assign bready = bready_q;
  assign arvalid = arvalid_q;
  assign rready = rready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout = timeout_q;
  assign rlast_err = rlast_err_q;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
  assign bad_resp_cnt = bad_q;
endmodule

// File: tb/tb_axi_txn_sequencer.sv
// tb_axi_txn_sequencer: directed checks of the AXI transaction sequencer against a reactive slave
module tb_axi_txn_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [31:0] count = '0;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic busy, done, timeout, rlast_err;
  logic [31:0] wr_cnt, rd_cnt, bad_resp_cnt;

  int checks = 0, errors = 0;
  int aw_lat = 0, ar_lat = 0, aw_w = 0, ar_w = 0;
  bit b_never = 1'b0, spur = 1'b0;
  logic [1:0] bresp_tab [4];
  logic rlast_tab [4];
  int n_aw_only = 0, n_bready = 0, n_done = 0;
  int lat, base_aw, base_b, d0;
  logic [3:0] first;

  axi_txn_sequencer #(.CNT_W(32), .TO_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .count(count),
    .awvalid(awvalid), .wvalid(wvalid), .bready(bready), .arvalid(arvalid), .rready(rready),
    .awready(awready), .wready(wready), .bvalid(bvalid), .arready(arready), .rvalid(rvalid),
    .rlast(rlast), .bresp(bresp), .rresp(rresp), .busy(busy), .done(done), .timeout(timeout),
    .rlast_err(rlast_err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .bad_resp_cnt(bad_resp_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial forever begin
    @(negedge clk);
    if (spur) begin
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; arready = 1'b1; rvalid = 1'b1;
    end else begin
      awready = awvalid && aw_w >= aw_lat;
      aw_w = (awvalid && !awready) ? aw_w + 1 : 0;
      wready = wvalid;
      bvalid = bready && !b_never;
      arready = arvalid && ar_w >= ar_lat;
      ar_w = (arvalid && !arready) ? ar_w + 1 : 0;
      rvalid = rready;
    end
    bresp = bvalid ? bresp_tab[wr_cnt[1:0]] : 2'b00;
    rlast = rvalid ? rlast_tab[rd_cnt[1:0]] : 1'b0;
    rresp = 2'b00;
    n_aw_only += int'(awvalid && !wvalid);
    n_bready += int'(bready);
    n_done += int'(done);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [31:0] n, input bit poke);
    @(negedge clk);
    start = 1'b1; mode = m; count = n;
    base_aw = n_aw_only; base_b = n_bready;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    first = {awvalid, wvalid, arvalid, busy};
    while (!done && lat < 200) begin
      start = poke && (lat == 2 || lat == 4);
      if (start) begin mode = 2'b10; count = 9; end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin bresp_tab[i] = 2'b00; rlast_tab[i] = 1'b1; end
    repeat (3) @(negedge clk);
    check("reset_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, timeout, rlast_err}, 0);
    check("reset_cnt", wr_cnt | rd_cnt | bad_resp_cnt, 0);
    reset = 1'b0;

    d0 = n_done;
    run(2'b01, 3, 0);
    check("wr3_lat", lat, 7);
    check("wr3_first", first, 4'b1101);
    check("wr3_wr", wr_cnt, 3);
    check("wr3_rd", rd_cnt, 0);
    check("wr3_bad", bad_resp_cnt, 0);
    @(negedge clk);
    check("wr3_done_once", n_done - d0, 1);
    check("wr3_done_low", done, 0);

    aw_lat = 3; bresp_tab[1] = 2'b10;
    run(2'b11, 2, 0);
    check("wr_rd_lat", lat, 15);
    check("wr_rd_aw_only", n_aw_only - base_aw, 6);
    check("wr_rd_wr", wr_cnt, 2);
    check("wr_rd_rd", rd_cnt, 2);
    check("wr_rd_bad", bad_resp_cnt, 1);
    aw_lat = 0; bresp_tab[1] = 2'b00;

    rlast_tab[2] = 1'b0;
    run(2'b10, 4, 0);
    check("rd4_lat", lat, 9);
    check("rd4_first", first, 4'b0011);
    check("rd4_rd", rd_cnt, 4);
    check("rd4_wr", wr_cnt, 0);
    check("rd4_rlast_err", rlast_err, 1);
    check("rd4_timeout", timeout, 0);
    rlast_tab[2] = 1'b1;

    b_never = 1'b1;
    run(2'b01, 1, 0);
    check("to_lat", lat, 10);
    check("to_bready_cycles", n_bready - base_b, 8);
    check("to_flag", timeout, 1);
    check("to_ctl_low", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("to_wr", wr_cnt, 0);
    @(negedge clk);
    check("to_sticky", timeout, 1);
    b_never = 1'b0;

    run(2'b01, 0, 0);
    check("cnt0_lat", lat, 1);
    check("cnt0_first", first, 0);
    check("cnt0_timeout_clr", timeout, 0);
    run(2'b00, 5, 0);
    check("mode0_lat", lat, 1);
    check("mode0_first", first, 0);

    aw_lat = 2;
    run(2'b01, 2, 1);
    check("poke_lat", lat, 9);
    check("poke_wr", wr_cnt, 2);
    check("poke_rd", rd_cnt, 0);
    @(negedge clk);
    check("poke_idle", {busy, awvalid, arvalid}, 0);
    aw_lat = 0;

    ar_lat = 5;
    @(negedge clk);
    start = 1'b1; mode = 2'b10; count = 3;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_arvalid", arvalid, 1);
    d0 = n_done;
    #2 reset = 1'b1;
    #1 check("rst_async_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, timeout, rlast_err}, 0);
    check("rst_async_cnt", wr_cnt | rd_cnt | bad_resp_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_done", n_done - d0, 0);
    ar_lat = 0;
    run(2'b11, 1, 0);
    check("post_rst_lat", lat, 5);
    check("post_rst_cnts", {wr_cnt[15:0], rd_cnt[15:0]}, 32'h0001_0001);

    spur = 1'b1;
    run(2'b11, 2, 0);
    check("spur_lat", lat, 9);
    check("spur_wr", wr_cnt, 2);
    check("spur_rd", rd_cnt, 2);
    check("spur_bad", bad_resp_cnt, 0);
    spur = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_txn_sequencer.md
# axi_txn_sequencer

Sequencer for the single-beat AXI4 checker master. It drives the master's five channel controls (awvalid, wvalid, bready, arvalid, rready) through a programmed number of write and/or read transactions. It observes the slave-side ready/valid/resp signals and reports completion counts, bad responses and stalls. It sits between the test control registers and the AXI master shim, which supplies constant address, data, length and size.

## Interface
Parameters:
- CNT_W, 32, width of the transaction count and the completion counters
- TO_W, 16, width of the stall timer
- TIMEOUT, 1000, cycles without progress in one phase before abort (must be < 2^TO_W)

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, sampled only in IDLE
- mode  in  2  01 = writes only, 10 = reads only, 11 = write then read per iteration, 00 = no-op
- count  in  CNT_W  number of iterations, sampled on start
- awvalid, wvalid, bready, arvalid, rready  out  1 each  to the AXI master shim
- awready, wready, bvalid, arready, rvalid, rlast  in  1 each  from the slave
- bresp, rresp  in  2 each  from the slave
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a run
- timeout  out  1  sticky until the next accepted start
- rlast_err  out  1  sticky; an R beat arrived with rlast=0
- wr_cnt, rd_cnt  out  CNT_W each  completed B and R handshakes this run
- bad_resp_cnt  out  CNT_W  B/R handshakes with resp != 00, saturating

## Operation
- States: IDLE, WAW (AW and/or W pending), WB (awaiting B), RA (awaiting AR), RD (awaiting R).
- IDLE + start:
  - Latch count and mode, clear all counters and sticky flags.
  - mode 00 or count 0: go straight to the done pulse, with no channel activity.
  - mode 01/11: enter WAW.
  - mode 10: enter RA.
- WAW:
  - awvalid and wvalid rise together and fall independently, each the cycle after its own handshake.
  - Both handshakes may land in the same cycle.
  - When both are complete, go to WB.
- WB:
  - bready=1.
  - On bvalid&bready: increment wr_cnt; increment bad_resp_cnt if bresp != 00.
  - Then: mode 11 goes to RA; otherwise the iteration ends.
- RA: arvalid=1 until arready, then go to RD.
- RD:
  - rready=1.
  - On rvalid&rready: increment rd_cnt; increment bad_resp_cnt if rresp != 00; set rlast_err if rlast=0. The beat still ends the transaction.
- Iteration end:
  - Iteration counter increments.
  - If it equals the latched count: go to IDLE with done=1 and busy=0.
  - Otherwise: start the next iteration at WAW (modes 01/11) or RA (mode 10).
- Stall timer:
  - Clears on every state entry and on every handshake; otherwise increments while busy.
  - On reaching TIMEOUT: set timeout, drop all five controls, pulse done, go to IDLE.
  - This deliberate mid-handshake abort violates AXI; the slave must be reset before the next run.
- Ready-side signals arriving while the matching valid/ready is low are ignored.
- start while busy is ignored; count and mode changes while busy have no effect.
- bad_resp_cnt saturates at all-ones; wr_cnt and rd_cnt cannot exceed count.

## Timing
- All outputs are registered.
- Reset value of every output is 0, applied asynchronously; the state machine returns to IDLE.
- Reset mid-run drops all valids and readies immediately. No done pulse is produced.
- Start latency: start at edge N gives busy=1 and the first valid(s) at cycle N+1.
- Handshake at edge k: the corresponding valid/ready is low at cycle k+1. The next phase's control is high at k+1 (no bubble).
- Minimum iteration length with zero-wait slave:
  - Write: 2 cycles (WAW, WB).
  - Read: 2 cycles (RA, RD).
  - mode 11: 4 cycles.
- done is asserted the cycle after the final B/R handshake, coincident with busy=0.

## Structure
- Package axi_seq_pkg holds:
  - the state enum;
  - mode constants MODE_NONE, MODE_WR, MODE_RD, MODE_WR_RD;
  - RESP_OKAY = 2'b00.
- Sub-module axi_seq_stall_timer (TO_W, TIMEOUT) handles the stall timer.
  - Inputs: clear, enable.
  - Output: one-cycle expired.
- Everything else lives in the top module.

## Test plan
- mode 01, count 3, zero-wait slave with OKAY responses -> 3 AW/W/B sequences, wr_cnt=3, rd_cnt=0, done 6 cycles after start's cycle+1, bad_resp_cnt=0.
- mode 11, count 2, awready delayed 3 cycles after wready, bresp=10 on the second write -> wvalid drops first, awvalid held 3 more cycles; wr_cnt=2, rd_cnt=2, bad_resp_cnt=1.
- mode 10, count 4, rvalid with rlast=0 on the third beat -> rd_cnt=4, rlast_err=1, no stall.
- mode 01, count 1, slave never asserts bvalid, TIMEOUT=8 -> bready high 8 cycles then low; timeout=1, done pulse, wr_cnt=0.
- start with count=0, then start pulses during a run -> immediate done with no valids; the mid-run starts are ignored and counts are unchanged.
- reset asserted while arvalid=1 -> all outputs 0 asynchronously, no done; a fresh start afterwards completes normally.
